eth_tx_segmenter: RTL and testbench

ETH_TX_SEGMENTER -- requirements
Module: eth_tx_segmenter

---
 rtl/eth_pkg.sv | 17 +
 rtl/axis_pipe_reg.sv | 41 ++++
 rtl/eth_tx_segmenter.sv | 125 ++++++++++++
 tb/tb_eth_tx_segmenter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet transmit-path definitions: minimum payload size and the
// segmenter state encoding.
package eth_pkg;

   localparam int MIN_PAYLOAD_BYTES = 46;

   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } seg_state_e;

   // A configured limit of zero would never terminate a segment, so it acts as one.
   function automatic logic [7:0] eff_limit(input logic [7:0] cfg);
      return (cfg == 8'd0) ? 8'd1 : cfg;
   endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// One-stage AXI-Stream output register.
// Handshake: a beat moves when valid && ready on the same rising edge; the
// producer holds valid and payload until it moves; ready never waits on valid.
module axis_pipe_reg #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic [KEEP_WIDTH-1:0] s_keep,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [KEEP_WIDTH-1:0] m_keep,
   output logic                  m_last
);

   // Refill in the same cycle the held beat drains, so full throughput has no bubble.
   assign s_ready = !m_valid || m_ready;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_keep  <= '0;
         m_last  <= 1'b0;
      end else if (s_valid && s_ready) begin
         m_valid <= 1'b1;
         m_data  <= s_data;
         m_keep  <= s_keep;
         m_last  <= s_last;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/eth_tx_segmenter.sv
// Cuts an unbounded payload stream into segments of at most cfg_max_beats
// beats, padding short single-beat segments up to the minimum payload size.
module eth_tx_segmenter
   import eth_pkg::*;
#(
   parameter int DATA_WIDTH        = 512,
   parameter int DEFAULT_MAX_BEATS = 23
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   input  logic [7:0]              cfg_max_beats,
   output logic [31:0]             stat_segments,
   output logic [31:0]             stat_padded,
   output logic                    dbg_state,
   output logic [7:0]              dbg_beat_cnt
);

   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int KCW        = $clog2(KEEP_WIDTH + 1);

   seg_state_e            state;
   logic [7:0]            beat_cnt;
   logic [7:0]            seg_limit;
   logic [7:0]            cur_limit;
   logic                  s_accept;
   logic                  first_beat;
   logic                  seg_end;
   logic                  pad_needed;
   logic [KCW-1:0]        keep_cnt;
   logic [DATA_WIDTH-1:0] out_data;
   logic [KEEP_WIDTH-1:0] out_keep;

   assign s_accept   = s_axis_tvalid && s_axis_tready;
   assign first_beat = (state == IDLE);
   // The first beat of a segment uses the live config; later beats use the latched copy.
   assign cur_limit  = first_beat ? eff_limit(cfg_max_beats) : seg_limit;
   assign seg_end    = s_axis_tlast || ((beat_cnt + 8'd1) == cur_limit);

   always_comb begin
      keep_cnt = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         keep_cnt = keep_cnt + KCW'(s_axis_tkeep[i]);
      end
   end

   assign pad_needed = first_beat && seg_end && (keep_cnt < KCW'(MIN_PAYLOAD_BYTES));

   // Padding fills only the missing low lanes with zeros; valid bytes are untouched.
   always_comb begin
      out_data = s_axis_tdata;
      out_keep = s_axis_tkeep;
      if (pad_needed) begin
         for (int i = 0; i < MIN_PAYLOAD_BYTES; i++) begin
            if (!s_axis_tkeep[i]) begin
               out_data[i*8 +: 8] = 8'h00;
               out_keep[i]        = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state       <= IDLE;
         beat_cnt    <= 8'd0;
         seg_limit   <= 8'(DEFAULT_MAX_BEATS);
         stat_padded <= 32'd0;
      end else if (s_accept) begin
         if (first_beat) begin
            seg_limit <= cur_limit;
         end
         if (seg_end) begin
            state    <= IDLE;
            beat_cnt <= 8'd0;
         end else begin
            state    <= BODY;
            beat_cnt <= beat_cnt + 8'd1;
         end
         if (pad_needed) begin
            stat_padded <= stat_padded + 32'd1;
         end
      end
   end

   // Segments are counted where they leave the block, not where they are formed.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         stat_segments <= 32'd0;
      end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
         stat_segments <= stat_segments + 32'd1;
      end
   end

   assign dbg_state    = state;
   assign dbg_beat_cnt = beat_cnt;

   axis_pipe_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH)
   ) u_out_reg (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .s_valid  (s_axis_tvalid),
      .s_ready  (s_axis_tready),
      .s_data   (out_data),
      .s_keep   (out_keep),
      .s_last   (seg_end),
      .m_valid  (m_axis_tvalid),
      .m_ready  (m_axis_tready),
      .m_data   (m_axis_tdata),
      .m_keep   (m_axis_tkeep),
      .m_last   (m_axis_tlast)
   );

endmodule

// File: tb/tb_eth_tx_segmenter.sv
// Directed bench for eth_tx_segmenter: segmentation, padding, stall and
// mid-frame reset behaviour against hand-computed expectations.
module tb_eth_tx_segmenter;

   localparam logic [63:0] K_FULL = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] K_10B  = 64'h0000_0000_0000_03FF;
   localparam logic [63:0] K_45B  = 64'h0000_1FFF_FFFF_FFFF;
   localparam logic [63:0] K_46B  = 64'h0000_3FFF_FFFF_FFFF;

   logic         ap_clk = 1'b0;
   logic         ap_rst_n = 1'b0;
   logic         s_tvalid = 1'b0;
   logic         s_axis_tready;
   logic [511:0] s_tdata = '0;
   logic [63:0]  s_tkeep = '0;
   logic         s_tlast = 1'b0;
   logic         m_axis_tvalid;
   logic         m_ready = 1'b1;
   logic [511:0] m_axis_tdata;
   logic [63:0]  m_axis_tkeep;
   logic         m_axis_tlast;
   logic [7:0]   cfg = 8'd4;
   logic [31:0]  stat_segments;
   logic [31:0]  stat_padded;
   logic         dbg_state;
   logic [7:0]   dbg_beat_cnt;

   int errors = 0;
   int checks = 0;
   logic toggle_en = 1'b0;
   int exp_seg = 0;
   int exp_pad = 0;

   logic [511:0] exp_d_q[$];
   logic [63:0]  exp_k_q[$];
   logic         exp_l_q[$];
   logic [511:0] obs_d_q[$];
   logic [63:0]  obs_k_q[$];
   logic         obs_l_q[$];

   logic         stall_pend = 1'b0;
   logic [511:0] held_d;
   logic [63:0]  held_k;
   logic         held_l;

   eth_tx_segmenter dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tlast  (s_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_ready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .cfg_max_beats (cfg),
      .stat_segments (stat_segments),
      .stat_padded   (stat_padded),
      .dbg_state     (dbg_state),
      .dbg_beat_cnt  (dbg_beat_cnt)
   );

   // Clock / reset block
   always #5 ap_clk = ~ap_clk;

   always @(negedge ap_clk) m_ready = toggle_en ? ~m_ready : 1'b1;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mk_data(input logic [7:0] seed);
      logic [511:0] d;
      for (int i = 0; i < 64; i++) d[i*8 +: 8] = seed + 8'(i);
      return d;
   endfunction

   // Expected payload of a padded beat: lanes nbytes..45 become zero.
   function automatic logic [511:0] pad_exp(input logic [511:0] d, input int nbytes);
      logic [511:0] r;
      r = d;
      for (int i = nbytes; i < 46; i++) r[i*8 +: 8] = 8'h00;
      return r;
   endfunction

   task automatic push_exp(input logic [511:0] d, input logic [63:0] k, input logic l);
      exp_d_q.push_back(d);
      exp_k_q.push_back(k);
      exp_l_q.push_back(l);
   endtask

   // Driver: present one beat at negedge, hold until accepted, then drop valid.
   task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l);
      int waitc;
      waitc = 0;
      @(negedge ap_clk);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      #1;
      while (!s_axis_tready && waitc < 100) begin
         @(negedge ap_clk);
         #1;
         waitc++;
      end
      chk("send_ready", 512'(s_axis_tready), 512'(1'b1));
      @(posedge ap_clk);
      #1;
      s_tvalid = 1'b0;
   endtask

   // Scoreboard: wait for the expected number of output beats, then compare in order.
   task automatic drain(input string tag);
      int n;
      logic [511:0] od;
      logic [63:0]  ok;
      logic         ol;
      n = 0;
      while (obs_d_q.size() < exp_d_q.size() && n < 300) begin
         @(posedge ap_clk);
         n++;
      end
      repeat (3) @(posedge ap_clk);
      #1;
      chk($sformatf("%s beat_count", tag), 512'(obs_d_q.size()), 512'(exp_d_q.size()));
      while (exp_d_q.size() > 0) begin
         if (obs_d_q.size() > 0) begin
            od = obs_d_q.pop_front();
            ok = obs_k_q.pop_front();
            ol = obs_l_q.pop_front();
         end else begin
            od = 'x;
            ok = 'x;
            ol = 1'bx;
         end
         chk($sformatf("%s data", tag), od, exp_d_q.pop_front());
         chk($sformatf("%s keep", tag), 512'(ok), 512'(exp_k_q.pop_front()));
         chk($sformatf("%s last", tag), 512'(ol), 512'(exp_l_q.pop_front()));
      end
      obs_d_q.delete();
      obs_k_q.delete();
      obs_l_q.delete();
      chk($sformatf("%s stat_segments", tag), 512'(stat_segments), 512'(exp_seg));
      chk($sformatf("%s stat_padded", tag), 512'(stat_padded), 512'(exp_pad));
   endtask

   // Output monitor: records handshakes, checks hold-while-stalled and ready rule.
   always @(negedge ap_clk) begin
      #2;
      if (ap_rst_n) begin
         chk("s_tready_rule", 512'(s_axis_tready), 512'(!m_axis_tvalid || m_ready));
         if (stall_pend) begin
            chk("stall_valid", 512'(m_axis_tvalid), 512'(1'b1));
            chk("stall_data", m_axis_tdata, held_d);
            chk("stall_keep", 512'(m_axis_tkeep), 512'(held_k));
            chk("stall_last", 512'(m_axis_tlast), 512'(held_l));
         end
         stall_pend = m_axis_tvalid && !m_ready;
         held_d = m_axis_tdata;
         held_k = m_axis_tkeep;
         held_l = m_axis_tlast;
         if (m_axis_tvalid && m_ready) begin
            obs_d_q.push_back(m_axis_tdata);
            obs_k_q.push_back(m_axis_tkeep);
            obs_l_q.push_back(m_axis_tlast);
         end
      end else begin
         stall_pend = 1'b0;
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge ap_clk);
      #1;
      chk("rst m_tvalid", 512'(m_axis_tvalid), 512'(1'b0));
      chk("rst m_tlast", 512'(m_axis_tlast), 512'(1'b0));
      chk("rst m_tdata", m_axis_tdata, 512'(0));
      chk("rst m_tkeep", 512'(m_axis_tkeep), 512'(0));
      chk("rst stat_segments", 512'(stat_segments), 512'(0));
      chk("rst stat_padded", 512'(stat_padded), 512'(0));
      chk("rst state", 512'(dbg_state), 512'(1'b0));
      chk("rst beat_cnt", 512'(dbg_beat_cnt), 512'(0));
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      #1;
      chk("release s_tready", 512'(s_axis_tready), 512'(1'b1));

      // cfg=4, 10 full beats -> segments 4/4/2
      cfg = 8'd4;
      for (int i = 1; i <= 10; i++) begin
         send(mk_data(8'(i)), K_FULL, i == 10);
         push_exp(mk_data(8'(i)), K_FULL, (i == 4) || (i == 8) || (i == 10));
      end
      exp_seg = 3;
      drain("seg4x10");
      chk("seg4x10 state", 512'(dbg_state), 512'(1'b0));

      // Single 10-byte beat -> padded to 46 bytes
      send(mk_data(8'h20), K_10B, 1'b1);
      push_exp(pad_exp(mk_data(8'h20), 10), K_46B, 1'b1);
      exp_seg = 4;
      exp_pad = 1;
      drain("pad10");

      // cfg=3 with 3-beat frame, tlast coincides with limit -> one segment
      cfg = 8'd3;
      send(mk_data(8'h30), K_FULL, 1'b0);
      chk("frame3 state_body", 512'(dbg_state), 512'(1'b1));
      chk("frame3 beat_cnt", 512'(dbg_beat_cnt), 512'(1));
      send(mk_data(8'h31), K_FULL, 1'b0);
      send(mk_data(8'h32), K_FULL, 1'b1);
      push_exp(mk_data(8'h30), K_FULL, 1'b0);
      push_exp(mk_data(8'h31), K_FULL, 1'b0);
      push_exp(mk_data(8'h32), K_FULL, 1'b1);
      exp_seg = 5;
      drain("frame3");

      // cfg=0 acts as 1: three single-beat segments, only the short one padded
      cfg = 8'd0;
      send(mk_data(8'h40), K_FULL, 1'b0);
      send(mk_data(8'h41), K_FULL, 1'b0);
      send(mk_data(8'h42), K_10B, 1'b1);
      push_exp(mk_data(8'h40), K_FULL, 1'b1);
      push_exp(mk_data(8'h41), K_FULL, 1'b1);
      push_exp(pad_exp(mk_data(8'h42), 10), K_46B, 1'b1);
      exp_seg = 8;
      exp_pad = 2;
      drain("cfg0");

      // Boundary: 46 bytes untouched, 45 bytes padded by one zero byte
      cfg = 8'd4;
      send(mk_data(8'h50), K_46B, 1'b1);
      send(mk_data(8'h60), K_45B, 1'b1);
      push_exp(mk_data(8'h50), K_46B, 1'b1);
      push_exp(pad_exp(mk_data(8'h60), 45), K_46B, 1'b1);
      exp_seg = 10;
      exp_pad = 3;
      drain("pad_boundary");

      // Mid-segment cfg change only affects the next segment
      cfg = 8'd2;
      send(mk_data(8'h70), K_FULL, 1'b0);
      cfg = 8'd5;
      send(mk_data(8'h71), K_FULL, 1'b0);
      send(mk_data(8'h72), K_FULL, 1'b0);
      send(mk_data(8'h73), K_FULL, 1'b0);
      send(mk_data(8'h74), K_FULL, 1'b1);
      push_exp(mk_data(8'h70), K_FULL, 1'b0);
      push_exp(mk_data(8'h71), K_FULL, 1'b1);
      push_exp(mk_data(8'h72), K_FULL, 1'b0);
      push_exp(mk_data(8'h73), K_FULL, 1'b0);
      push_exp(mk_data(8'h74), K_FULL, 1'b1);
      exp_seg = 12;
      drain("cfg_change");

      // Toggling m_axis_tready over a 6-beat stream
      cfg = 8'd8;
      toggle_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send(mk_data(8'h80 + 8'(i)), K_FULL, i == 5);
         push_exp(mk_data(8'h80 + 8'(i)), K_FULL, i == 5);
      end
      toggle_en = 1'b0;
      exp_seg = 13;
      drain("stall");

      // Reset after beat 2 of a 5-beat frame
      send(mk_data(8'h90), K_FULL, 1'b0);
      send(mk_data(8'h91), K_FULL, 1'b0);
      push_exp(mk_data(8'h90), K_FULL, 1'b0);
      ap_rst_n = 1'b0;
      #1;
      chk("midrst m_tvalid", 512'(m_axis_tvalid), 512'(1'b0));
      chk("midrst m_tdata", m_axis_tdata, 512'(0));
      chk("midrst m_tkeep", 512'(m_axis_tkeep), 512'(0));
      chk("midrst m_tlast", 512'(m_axis_tlast), 512'(1'b0));
      chk("midrst state", 512'(dbg_state), 512'(1'b0));
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      #1;
      chk("midrst release s_tready", 512'(s_axis_tready), 512'(1'b1));
      exp_seg = 0;
      exp_pad = 0;
      drain("midrst");
      send(mk_data(8'hA0), K_FULL, 1'b0);
      send(mk_data(8'hA1), K_FULL, 1'b1);
      push_exp(mk_data(8'hA0), K_FULL, 1'b0);
      push_exp(mk_data(8'hA1), K_FULL, 1'b1);
      exp_seg = 1;
      drain("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
